// File: rtl/rx_fifo_buffer.sv
// rx_fifo_buffer
//   Receive-side byte FIFO between the UART receiver and the register block.
//   The receiver pushes completed bytes and the register block pops one byte per
//   CPU read of RXR. The head entry is always visible on rd_data_o (show-ahead).
//   The block also provides empty/full/level status, an RX threshold flag and a
//   sticky overrun flag.
//
// Build option
//   RX_FIFO_ERROR_TAG_EN : when defined, each entry also stores the frame and
//                          parity error bits of its byte, and presents them on
//                          head_*_err_o. When undefined, those inputs are ignored
//                          and the head tag outputs are tied low. The port list is
//                          the same in both builds.
//
// Ports
//   clk_i, rst_i         clock (rising edge), synchronous active-high reset
//   write_i, wr_data_i   push strobe and received byte
//   frame_err_i          frame error of the byte being pushed
//   parity_err_i         parity error of the byte being pushed
//   read_i               pop strobe
//   flush_i              discard all contents (beats read/write)
//   threshold_i          RX threshold, 0 disables threshold_o
//   overrun_clr_i        clears the sticky overrun flag
//   rd_data_o            head byte, 0 while empty
//   head_frame_err_o     frame error tag of head byte
//   head_parity_err_o    parity error tag of head byte
//   empty_o, full_o      status decoded from the entry count
//   level_o              entry count 0..DEPTH
//   threshold_o          level_o >= threshold_i and threshold_i != 0
//   overrun_o            sticky: a push was dropped because the FIFO was full

module rx_fifo_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  write_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  frame_err_i,
  input  logic                  parity_err_i,
  input  logic                  read_i,
  input  logic                  flush_i,
  input  logic [5:0]            threshold_i,
  input  logic                  overrun_clr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  head_frame_err_o,
  output logic                  head_parity_err_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [PTR_W:0]        level_o,
  output logic                  threshold_o,
  output logic                  overrun_o
);

`ifdef RX_FIFO_ERROR_TAG_EN
  localparam int ENTRY_W = DATA_WIDTH + 2;
`else
  localparam int ENTRY_W = DATA_WIDTH;
`endif

  // Common width for the threshold compare so either side can be the wider one.
  localparam int CMP_W = (PTR_W + 1 > 6) ? PTR_W + 1 : 6;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               overrun;

  logic               push;
  logic               pop;
  logic               drop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [CMP_W-1:0]   level_ext;
  logic [CMP_W-1:0]   thr_ext;

  // Status is decoded from the registered count only.
  assign empty_o = (count == '0);
  assign full_o  = (count == (PTR_W+1)'(DEPTH));
  assign level_o = count;

  // A full FIFO can still accept a push when a pop frees the head slot in the
  // same cycle. Flush discards both strobes, and a flushed push is not an overrun.
  assign push = write_i && (!full_o || read_i) && !flush_i;
  assign pop  = read_i && !empty_o && !flush_i;
  assign drop = write_i && full_o && !read_i && !flush_i;

`ifdef RX_FIFO_ERROR_TAG_EN
  assign wr_entry = {frame_err_i, parity_err_i, wr_data_i};
`else
  logic unused_tags;
  assign unused_tags = frame_err_i ^ parity_err_i;
  assign wr_entry    = wr_data_i;
`endif

  // Storage array carries no reset; stale entries are hidden by the pointers.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers and count. Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Sticky overrun: setting wins over a clear in the same cycle; flush leaves it alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (overrun_clr_i) begin
      overrun <= 1'b0;
    end
  end

  assign overrun_o = overrun;

  // Show-ahead head entry, forced to zero while empty.
  assign head_entry = empty_o ? '0 : mem[rd_ptr];
  assign rd_data_o  = head_entry[DATA_WIDTH-1:0];

`ifdef RX_FIFO_ERROR_TAG_EN
  assign head_frame_err_o  = head_entry[DATA_WIDTH+1];
  assign head_parity_err_o = head_entry[DATA_WIDTH];
`else
  assign head_frame_err_o  = 1'b0;
  assign head_parity_err_o = 1'b0;
`endif

  assign level_ext   = CMP_W'(count);
  assign thr_ext     = CMP_W'(threshold_i);
  assign threshold_o = (threshold_i != 6'd0) && (level_ext >= thr_ext);

endmodule
